seq_addsub: RTL and testbench
=============================

// Module: seq_addsub
// PURPOSE
//  Parametrised multi-cycle adder/subtractor.
//  - Captures two WIDTH-bit operands on start.
//  - Resolves the carry chain CHUNK bits per clock, with the carry registered between chunks.
//  - Reports sum, carry-out, signed overflow and zero, with a start/busy/done handshake.
//  - Successor to the fixed 3-bit combinational ripple adder: used where wide operands
//    must not form one long combinational carry path.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be >= 2
//  CHUNK  2  bits resolved per cycle; WIDTH % CHUNK == 0 (elaboration error otherwise)
//  NCH = WIDTH/CHUNK (derived localparam, not overridable)
// PORTS
//  clk     in   1      single clock, rising edge
//  resetn  in   1      asynchronous, active-low reset
//  start   in   1      request; samples a, b, sub on the same edge
//  sub     in   1      0: a+b; 1: a-b (two's complement)
//  a       in   WIDTH  operand A
//  b       in   WIDTH  operand B
//  busy    out  1      high while in RUN
//  done    out  1      one-cycle pulse; result outputs valid
//  sum     out  WIDTH  result
//  cout    out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf     out  1      signed overflow
//  zero    out  1      sum == 0
// BEHAVIOUR
//  - Reset (resetn low, async): state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0, zero=0.
//    Internal operand/carry/chunk-index registers cleared.
//  - Reset mid-RUN aborts the operation; no done pulse is produced.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE/DONE, start=1 at edge E:
//    - Latch a, b^{WIDTH{sub}}; carry=sub; idx=0; next state RUN.
//  - RUN, edges E+1..E+NCH:
//    - Add chunk idx of A and B plus carry; write the CHUNK result bits into sum; carry <= chunk cout.
//    - At edge E+NCH: cout, ovf, zero updated; next state DONE.
//  - DONE: done=1 for exactly one cycle, then IDLE; or RUN again if start=1 (back-to-back).
//  - Latency: done is high in the cycle after edge E+NCH.
//    - Throughput: one result per NCH+1 cycles.
//  - start while busy=1: ignored; operands and the in-flight operation unaffected.
//  - sum, cout, ovf, zero:
//    - Hold their value from DONE until the next operation's RUN begins updating them.
//    - sum bits change chunk-wise during RUN; cout/ovf/zero change only at the final RUN edge.
//  - ovf = carry into MSB XOR carry out of MSB.
//  - All arithmetic is modulo 2^WIDTH.
// CONFIGURATION
//  ADDSUB_SAT_EN
//  - Defined: on ovf=1, sum presented in DONE is clamped to the signed limit.
//    - 0111..1 when the true result is positive; 1000..0 when negative.
//    - The sign is taken from the operand MSB (both operands share it on overflow).
//    - ovf is still reported as 1.
//  - Undefined: sum always wraps; no clamp logic is built.
// TESTING (WIDTH=8, CHUNK=2, NCH=4)
//  1. a=0x05, b=0x03, sub=0 -> 4th edge after start: done=1, sum=0x08, cout=0, ovf=0, zero=0.
//  2. a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0, zero=1.
//  3. a=0x00, b=0x01, sub=1 -> sum=0xFF, cout=0 (borrow), ovf=0.
//     Then a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1.
//  4. a=0x7F, b=0x01, sub=0 -> ovf=1; sum=0x80 without ADDSUB_SAT_EN, 0x7F with it.
//     Also a=0x80, b=0x80 -> ovf=1, cout=1; sum=0x00 wrap, 0x80 with ADDSUB_SAT_EN.
//  5. start with 0x10+0x20; re-assert start with 0xAA+0x55 at RUN cycle 2
//     -> ignored; done once, sum=0x30, busy high exactly 4 cycles.
//     Start in the DONE cycle -> new op accepted; done again 4 edges later.
//  6. resetn low at RUN cycle 2 (async, mid-cycle)
//     -> busy, done, sum, cout, ovf, zero all 0 immediately.
//     After release, no done until a new start; a new op completes correctly.

Source files
------------

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor that resolves CHUNK bits per clock with a registered carry.
// Optional macro ADDSUB_SAT_EN clamps the result to the signed limit when overflow occurs.
//
// state | meaning
// IDLE  | waiting for start, last result held on outputs
// RUN   | one chunk of the carry chain resolved per clock
// DONE  | result valid for one cycle, start accepted back-to-back
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  if ((WIDTH < 2) || (CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_param_check
    $error("seq_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] op_a, op_b;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] ca, cb;
  logic [CHUNK:0]   chunk_full;
  logic [WIDTH-1:0] sum_next, sum_final;
  logic             msb_cin, ovf_n, load, last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign load = start && (state != RUN);
  assign last = (idx == LAST);

  assign ca         = op_a[int'(idx) * CHUNK +: CHUNK];
  assign cb         = op_b[int'(idx) * CHUNK +: CHUNK];
  assign chunk_full = {1'b0, ca} + {1'b0, cb} + (CHUNK + 1)'(carry);

  // The MSB's own sum bit reveals its carry-in: s = a ^ b ^ cin.
  assign msb_cin = chunk_full[CHUNK-1] ^ op_a[WIDTH-1] ^ op_b[WIDTH-1];
  assign ovf_n   = msb_cin ^ chunk_full[CHUNK];

  always_comb begin
    sum_next = sum;
    sum_next[int'(idx) * CHUNK +: CHUNK] = chunk_full[CHUNK-1:0];
  end

`ifdef ADDSUB_SAT_EN
  // On overflow both operands share the sign, so op_a's MSB picks the limit.
  always_comb begin
    sum_final = sum_next;
    if (ovf_n)
      sum_final = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign sum_final = sum_next;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (load) begin
      op_a  <= a;
      op_b  <= b ^ {WIDTH{sub}};
      carry <= sub;
      idx   <= '0;
    end else if (state == RUN) begin
      carry <= chunk_full[CHUNK];
      idx   <= idx + 1'b1;
      if (last) begin
        sum  <= sum_final;
        cout <= chunk_full[CHUNK];
        ovf  <= ovf_n;
        zero <= (sum_final == '0);
      end else begin
        sum  <= sum_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Directed, table-driven bench for seq_addsub (WIDTH=8, CHUNK=2), plus hand-written
// sequences for start-while-busy, back-to-back start and mid-operation reset.
module tb_seq_addsub;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout, ovf, zero;
  logic [7:0] sum;

  int n_chk = 0;
  int n_err = 0;

  seq_addsub #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .resetn(resetn), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one op; return cycles from the first post-start negedge until done shows.
  task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic vs,
                       output int lat);
    @(negedge clk);
    start = 1'b1; a = va; b = vb; sub = vs;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int lat;
    logic [7:0] es;
    logic ez;
    es = v.sum;
    ez = v.zero;
`ifdef ADDSUB_SAT_EN
    if (v.ovf) begin
      es = v.a[7] ? 8'h80 : 8'h7F;
      ez = 1'b0;
    end
`endif
    issue(v.a, v.b, v.sub, lat);
    chk($sformatf("v%0d latency", i), lat, 4);
    chk($sformatf("v%0d sum", i), sum, es);
    chk($sformatf("v%0d cout", i), cout, v.cout);
    chk($sformatf("v%0d ovf", i), ovf, v.ovf);
    chk($sformatf("v%0d zero", i), zero, ez);
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", i), done, 0);
    chk($sformatf("v%0d sum_hold", i), sum, es);
  endtask

  initial begin
    int lat, busy_cnt, done_cnt;
    logic [7:0] done_sum;

    vecs[0]  = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};

    // Reset state
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
    chk("rst ovf", ovf, 0);
    chk("rst zero", zero, 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h20; sub = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_sum = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = (c == 2);
      if (c == 2) begin a = 8'hAA; b = 8'h55; end
      else begin a = 8'h00; b = 8'h00; end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_sum = sum; end
    end
    start = 1'b0;
    chk("busy_ignore busy_cycles", busy_cnt, 4);
    chk("busy_ignore done_count", done_cnt, 1);
    chk("busy_ignore sum", done_sum, 8'h30);

    // Back-to-back: new start in the DONE cycle
    issue(8'h01, 8'h02, 1'b0, lat);
    chk("b2b first latency", lat, 4);
    chk("b2b first sum", sum, 8'h03);
    start = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy after done", busy, 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b second latency", lat, 4);
    chk("b2b second sum", sum, 8'h33);

    // Reset in the middle of RUN; previous sum 0x33 must clear at once
    @(negedge clk);
    start = 1'b1; a = 8'hF0; b = 8'h0F; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst sum", sum, 0);
    chk("midrst cout", cout, 0);
    chk("midrst ovf", ovf, 0);
    chk("midrst zero", zero, 0);
    @(negedge clk);
    resetn = 1'b1;
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("midrst no_activity", done_cnt, 0);
    issue(8'h05, 8'h03, 1'b0, lat);
    chk("post_rst latency", lat, 4);
    chk("post_rst sum", sum, 8'h08);
    chk("post_rst zero", zero, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
